// File: rtl/twiddle_gen_qw.sv
// twiddle_gen_qw
//   Twiddle-factor generator for radix-2 FFT stages. A quarter-wave cosine
//   table of N/4+1 entries is built at elaboration. The full factor
//   W_N^k = {cos(-2*pi*k/N), sin(-2*pi*k/N)} for k in [0, N/2) is rebuilt
//   from that table by quadrant folding. The result goes through a 2-stage
//   pipeline that accepts one sample per cycle.
//
// Ports
//   clk       clock, all state changes on the rising edge
//   rst_n     asynchronous active-low reset
//   in_valid  addr/inv are sampled this cycle
//   addr      twiddle index k, 0..N/2-1 (AW bits)
//   inv       1 = inverse transform, conjugate the output
//   tf_valid  tf_out holds a new result
//   tf_out    {re[2W-1:W], im[W-1:0]}, signed, scale 2^(W-2)
module twiddle_gen_qw #(
  parameter int N = 128,
  parameter int W = 8,
  localparam int AW = $clog2(N) - 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [AW-1:0]   addr,
  input  logic            inv,
  output logic            tf_valid,
  output logic [2*W-1:0]  tf_out
);

  localparam int Q = N / 4;

  if (N < 8 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("twiddle_gen_qw: N must be a power of two and at least 8");
  end
  if (W < 2 || W > 32) begin : g_bad_w
    $error("twiddle_gen_qw: W must be in the range 2..32");
  end

  // Computes round(2^(W-2) * cos(2*pi*m/N)), rounding half away from zero.
  // The function uses 60-bit fixed point and a Taylor series, so it needs
  // no real math at elaboration. The angle is at most pi/2, so 24 terms
  // converge far below one LSB. The pi constant is truncated from its hex
  // expansion 3.243F6A8885A308D313...
  function automatic logic signed [W-1:0] cos_entry(input int m);
    logic signed [127:0] pi_fix;
    logic signed [127:0] x;
    logic signed [127:0] x2;
    logic signed [127:0] term;
    logic signed [127:0] sum;
    logic signed [127:0] mag;
    logic signed [127:0] r;
    pi_fix = 128'sh3243F6A8885A308D;
    x      = (pi_fix * 128'(2 * m)) / 128'(N);
    x2     = (x * x) >>> 60;
    term   = 128'sd1 <<< 60;
    sum    = term;
    for (int n = 1; n <= 24; n++) begin
      term = -((term * x2) >>> 60) / 128'(2 * n * (2 * n - 1));
      sum  = sum + term;
    end
    mag = (sum < 0) ? -sum : sum;
    r   = ((mag <<< (W - 2)) + (128'sd1 <<< 59)) >>> 60;
    if (sum < 0) begin
      r = -r;
    end
    return r[W-1:0];
  endfunction

  logic signed [W-1:0] cos_rom [0:Q];

  for (genvar gi = 0; gi <= Q; gi++) begin : g_rom
    localparam logic signed [W-1:0] CV = cos_entry(gi);
    assign cos_rom[gi] = CV;
  end

  // ---------------- stage 1: fold the index into the quarter table --------
  logic          v1_q, v1_d;
  logic [AW-1:0] re_idx_q, re_idx_d;
  logic [AW-1:0] im_idx_q, im_idx_d;
  logic          quad_q, quad_d;
  logic          inv1_q, inv1_d;

  logic [AW-1:0] low_idx;
  logic [AW-1:0] comp_idx;

  // The top address bit selects the second quadrant, because Q = 2^(AW-1).
  // In that quadrant the roles of the index j and of Q-j swap.
  always_comb begin
    low_idx  = {1'b0, addr[AW-2:0]};
    comp_idx = AW'(Q) - low_idx;
    v1_d     = in_valid;
    quad_d   = addr[AW-1];
    inv1_d   = inv;
    re_idx_d = addr[AW-1] ? comp_idx : low_idx;
    im_idx_d = addr[AW-1] ? low_idx  : comp_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      re_idx_q <= '0;
      im_idx_q <= '0;
      quad_q   <= 1'b0;
      inv1_q   <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      re_idx_q <= re_idx_d;
      im_idx_q <= im_idx_d;
      quad_q   <= quad_d;
      inv1_q   <= inv1_d;
    end
  end

  // ---------------- stage 2: table read, sign fix, output register --------
  logic            tf_valid_q, tf_valid_d;
  logic [2*W-1:0]  tf_out_q, tf_out_d;

  logic signed [W-1:0] re_tab;
  logic signed [W-1:0] im_tab;
  logic signed [W-1:0] re_val;
  logic signed [W-1:0] im_val;

  // The sine term is always -C[..] after folding. The inverse transform
  // cancels that negation. |C| <= 2^(W-2), so no negation can overflow.
  always_comb begin
    re_tab     = cos_rom[re_idx_q];
    im_tab     = cos_rom[im_idx_q];
    re_val     = quad_q ? -re_tab : re_tab;
    im_val     = inv1_q ? im_tab : -im_tab;
    tf_valid_d = v1_q;
    tf_out_d   = v1_q ? {re_val, im_val} : tf_out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tf_valid_q <= 1'b0;
      tf_out_q   <= '0;
    end else begin
      tf_valid_q <= tf_valid_d;
      tf_out_q   <= tf_out_d;
    end
  end

  assign tf_valid = tf_valid_q;
  assign tf_out   = tf_out_q;

endmodule
